cfi_shadow_stack_ctrl: RTL and testbench



---
 rtl/cfi_shadow_stack_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cfi_shadow_stack_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_shadow_stack_ctrl.sv
// Commit-stage CFI controller: queues call/return events from the commit ports and
// checks them one per cycle against a private shadow return-address stack.
module cfi_shadow_stack_ctrl #(
    parameter int NR_PORTS = 2,
    parameter int XLEN     = 64,
    parameter int SS_DEPTH = 16,
    parameter int Q_DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [NR_PORTS-1:0]        ev_valid_i,
    input  logic [NR_PORTS-1:0]        ev_call_i,
    input  logic [NR_PORTS-1:0]        ev_ret_i,
    input  logic [NR_PORTS*XLEN-1:0]   ev_link_i,
    input  logic [NR_PORTS*XLEN-1:0]   ev_target_i,
    output logic                       ev_ready_o,
    output logic                       alert_o,
    output logic [1:0]                 alert_cause_o,
    output logic [XLEN-1:0]            alert_addr_o,
    input  logic                       alert_ack_i,
    output logic [$clog2(SS_DEPTH):0]  depth_o,
    output logic                       busy_o
);

    localparam int QW = $clog2(Q_DEPTH);
    localparam int SW = $clog2(SS_DEPTH);
    localparam logic [QW:0] READY_MAX = (QW+1)'(Q_DEPTH - NR_PORTS);
    localparam logic [QW:0] Q_ONE     = (QW+1)'(1);
    localparam logic [SW:0] SS_FULL   = (SW+1)'(SS_DEPTH);
    localparam logic [SW:0] SP_ONE    = (SW+1)'(1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
    localparam logic [1:0] CAUSE_UNDER    = 2'b10;
    localparam logic [1:0] CAUSE_OVER     = 2'b11;

    typedef enum logic [1:0] {RUN, ALERT, FLUSH} state_t;

    typedef struct packed {
        logic            call;
        logic            ret;
        logic [XLEN-1:0] link;
        logic [XLEN-1:0] target;
    } entry_t;

    state_t          state, state_nxt;
    entry_t          q_mem [Q_DEPTH];
    logic [QW-1:0]   rd_ptr, wr_ptr;
    logic [QW:0]     q_count;
    logic [XLEN-1:0] stack [SS_DEPTH];
    logic [SW:0]     sp, sp_nxt;
    logic [SW-1:0]   sp_top;
    logic [1:0]      cause, cause_nxt;
    logic [XLEN-1:0] addr, addr_nxt;

    entry_t          head;
    logic            deq;
    logic            flush;
    logic            push_we;
    logic [SW-1:0]   push_idx;

    logic [NR_PORTS-1:0] enq_en;
    logic [QW-1:0]       enq_idx [NR_PORTS];
    logic [QW:0]         enq_cnt;

    // Handshake: a bundle presented on ev_valid_i is taken whole on an edge where
    // ev_ready_o is high; with ev_ready_o low the bundle is dropped, not held.
    assign ev_ready_o = (state == RUN) && (q_count <= READY_MAX);

    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            enq_en[i]  = ev_ready_o && ev_valid_i[i] && (ev_call_i[i] || ev_ret_i[i]);
            enq_idx[i] = wr_ptr + enq_cnt[QW-1:0];
            if (enq_en[i]) enq_cnt = enq_cnt + Q_ONE;
        end
    end

    assign head   = q_mem[rd_ptr];
    assign sp_top = sp[SW-1:0] - SW'(1);

    always_comb begin
        state_nxt = state;
        sp_nxt    = sp;
        cause_nxt = cause;
        addr_nxt  = addr;
        deq       = 1'b0;
        flush     = 1'b0;
        push_we   = 1'b0;
        push_idx  = sp[SW-1:0];
        case (state)
            RUN: begin
                if (q_count != '0) begin
                    deq = 1'b1;
                    if (enable_i) begin
                        if (head.ret && sp == '0) begin
                            state_nxt = ALERT;
                            cause_nxt = CAUSE_UNDER;
                            addr_nxt  = head.target;
                        end else if (head.ret && stack[sp_top] != head.target) begin
                            state_nxt = ALERT;
                            cause_nxt = CAUSE_MISMATCH;
                            addr_nxt  = head.target;
                        end else if (head.call && !head.ret && sp == SS_FULL) begin
                            state_nxt = ALERT;
                            cause_nxt = CAUSE_OVER;
                            addr_nxt  = head.link;
                        end else if (head.call) begin
                            // A coroutine entry pops and pushes into the same slot.
                            push_we  = 1'b1;
                            push_idx = head.ret ? sp_top : sp[SW-1:0];
                            if (!head.ret) sp_nxt = sp + SP_ONE;
                        end else if (head.ret) begin
                            sp_nxt = sp - SP_ONE;
                        end
                    end
                end
            end
            ALERT: begin
                if (alert_ack_i) begin
                    state_nxt = FLUSH;
                    flush     = 1'b1;
                    cause_nxt = CAUSE_NONE;
                    addr_nxt  = '0;
                end
            end
            FLUSH: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (!enable_i || flush) sp_nxt = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RUN;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
            sp      <= '0;
            cause   <= CAUSE_NONE;
            addr    <= '0;
        end else begin
            state <= state_nxt;
            sp    <= sp_nxt;
            cause <= cause_nxt;
            addr  <= addr_nxt;
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                q_count <= '0;
            end else begin
                rd_ptr  <= rd_ptr + QW'(deq);
                wr_ptr  <= wr_ptr + enq_cnt[QW-1:0];
                q_count <= q_count + enq_cnt - (QW+1)'(deq);
            end
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers and sp.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_PORTS; i++) begin
            if (enq_en[i]) begin
                q_mem[enq_idx[i]] <= '{call:   ev_call_i[i],
                                       ret:    ev_ret_i[i],
                                       link:   ev_link_i[i*XLEN +: XLEN],
                                       target: ev_target_i[i*XLEN +: XLEN]};
            end
        end
        if (push_we) stack[push_idx] <= head.link;
    end

    assign alert_o       = (state == ALERT);
    assign alert_cause_o = cause;
    assign alert_addr_o  = addr;
    assign depth_o       = sp;
    assign busy_o        = (q_count != '0) || (state != RUN);

endmodule

// File: tb/tb_cfi_shadow_stack_ctrl.sv
// Bench for cfi_shadow_stack_ctrl: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the event queue and shadow stack.
module tb_cfi_shadow_stack_ctrl;

    localparam int NR_PORTS = 2;
    localparam int XLEN     = 64;
    localparam int SS_DEPTH = 16;
    localparam int Q_DEPTH  = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      enable;
    logic [NR_PORTS-1:0]       ev_valid, ev_call, ev_ret;
    logic [NR_PORTS*XLEN-1:0]  ev_link, ev_target;
    logic                      ev_ready, alert, alert_ack, busy;
    logic [1:0]                alert_cause;
    logic [XLEN-1:0]           alert_addr;
    logic [$clog2(SS_DEPTH):0] depth;

    always #5 clk = ~clk;

    cfi_shadow_stack_ctrl #(
        .NR_PORTS(NR_PORTS), .XLEN(XLEN), .SS_DEPTH(SS_DEPTH), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .ev_valid_i(ev_valid), .ev_call_i(ev_call), .ev_ret_i(ev_ret),
        .ev_link_i(ev_link), .ev_target_i(ev_target),
        .ev_ready_o(ev_ready), .alert_o(alert), .alert_cause_o(alert_cause),
        .alert_addr_o(alert_addr), .alert_ack_i(alert_ack),
        .depth_o(depth), .busy_o(busy)
    );

    typedef struct {
        bit              call;
        bit              ret;
        logic [XLEN-1:0] link;
        logic [XLEN-1:0] tgt;
    } ev_t;

    ev_t             mq[$];
    logic [XLEN-1:0] mstk[$];
    int              mst;      // 0 running, 1 alert pending, 2 flushing
    logic [1:0]      mcause;
    logic [XLEN-1:0] maddr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input logic [1:0] c, input logic [XLEN-1:0] a);
        mst    = 1;
        mcause = c;
        maddr  = a;
    endtask

    task automatic exec(input ev_t e);
        bit bad = 0;
        if (e.ret) begin
            if (mstk.size() == 0) begin raise(2'b10, e.tgt); bad = 1; end
            else if (mstk[$] != e.tgt) begin raise(2'b01, e.tgt); bad = 1; end
            else void'(mstk.pop_back());
        end
        if (!bad && e.call) begin
            if (mstk.size() == SS_DEPTH) raise(2'b11, e.link);
            else mstk.push_back(e.link);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        if (rst) begin
            mq.delete(); mstk.delete(); mst = 0; mcause = 2'b00; maddr = '0;
            return;
        end
        case (mst)
            0: begin
                bit rdy = (Q_DEPTH - mq.size()) >= NR_PORTS;
                if (mq.size() > 0) begin
                    ev_t e = mq.pop_front();
                    if (enable) exec(e);
                end
                if (rdy) begin
                    for (int i = 0; i < NR_PORTS; i++) begin
                        if (ev_valid[i] && (ev_call[i] || ev_ret[i])) begin
                            ev_t n;
                            n.call = ev_call[i];
                            n.ret  = ev_ret[i];
                            n.link = ev_link[i*XLEN +: XLEN];
                            n.tgt  = ev_target[i*XLEN +: XLEN];
                            mq.push_back(n);
                        end
                    end
                end
            end
            1: begin
                if (alert_ack) begin
                    mq.delete(); mstk.delete(); mcause = 2'b00; maddr = '0; mst = 2;
                end
            end
            default: mst = 0;
        endcase
        if (!enable) mstk.delete();
    endtask

    task automatic check_all();
        check("ev_ready", ev_ready, ((mst == 0) && ((Q_DEPTH - mq.size()) >= NR_PORTS)) ? 1 : 0);
        check("alert", alert, (mst == 1) ? 1 : 0);
        check("cause", alert_cause, mcause);
        check("addr", alert_addr, maddr);
        check("depth", depth, mstk.size());
        check("busy", busy, (mq.size() > 0 || mst != 0) ? 1 : 0);
    endtask

    task automatic clear_inputs();
        rst = 0; alert_ack = 0;
        ev_valid = '0; ev_call = '0; ev_ret = '0; ev_link = '0; ev_target = '0;
    endtask

    task automatic set_port(input int p, input bit c, input bit r,
                            input logic [XLEN-1:0] link, input logic [XLEN-1:0] tgt);
        ev_valid[p] = 1'b1;
        ev_call[p]  = c;
        ev_ret[p]   = r;
        ev_link[p*XLEN +: XLEN]   = link;
        ev_target[p*XLEN +: XLEN] = tgt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        clear_inputs();
    endtask

    initial begin
        logic [XLEN-1:0] a;
        enable = 1'b1;
        clear_inputs();

        // reset
        rst = 1'b1;
        tick();
        check("rst_ready", ev_ready, 1);
        check("rst_depth", depth, 0);

        // push then matching pop
        set_port(0, 1, 0, 64'h8000_0010, 0);
        tick(); tick();
        check("push_depth", depth, 1);
        set_port(0, 0, 1, 0, 64'h8000_0010);
        tick(); tick();
        check("pop_depth", depth, 0);
        check("pop_alert", alert, 0);

        // mismatch, hold, ack, flush
        set_port(0, 1, 0, 64'h8000_0010, 0);
        tick(); tick();
        set_port(0, 0, 1, 0, 64'h8000_0020);
        tick(); tick();
        check("mm_alert", alert, 1);
        check("mm_cause", alert_cause, 2'b01);
        check("mm_addr", alert_addr, 64'h8000_0020);
        check("mm_ready", ev_ready, 0);
        repeat (5) tick();
        check("mm_hold_cause", alert_cause, 2'b01);
        alert_ack = 1'b1;
        tick();
        check("flush_alert", alert, 0);
        check("flush_busy", busy, 1);
        tick();
        check("post_flush_depth", depth, 0);
        check("post_flush_ready", ev_ready, 1);

        // underflow
        set_port(0, 0, 1, 0, 64'h1234);
        tick(); tick();
        check("uf_cause", alert_cause, 2'b10);
        check("uf_addr", alert_addr, 64'h1234);
        alert_ack = 1'b1;
        tick(); tick();

        // overflow: 17 calls
        for (int k = 0; k < 17; k++) begin
            set_port(0, 1, 0, 64'h9000_0000 + 64'(k * 4), 0);
            tick();
        end
        check("of_full_depth", depth, 16);
        tick();
        check("of_cause", alert_cause, 2'b11);
        check("of_addr", alert_addr, 64'h9000_0040);
        alert_ack = 1'b1;
        tick(); tick();

        // same-cycle call/ret bundle
        set_port(0, 1, 0, 64'h4000_0100, 0);
        set_port(1, 0, 1, 0, 64'h4000_0100);
        tick(); tick();
        check("bundle_mid_depth", depth, 1);
        tick();
        check("bundle_depth", depth, 0);
        check("bundle_alert", alert, 0);

        // back-to-back bundles, drops while not ready
        for (int k = 0; k < 12; k++) begin
            a = 64'(32'h5000_0000 + $urandom_range(0, 255) * 8);
            set_port(0, 1, 0, a, 0);
            set_port(1, 0, 1, 0, a);
            tick();
        end
        repeat (6) tick();
        check("burst_depth", depth, 0);
        check("burst_alert", alert, 0);

        // reset while alert pending with 3 queued entries
        set_port(0, 0, 1, 0, 64'h55);
        set_port(1, 1, 0, 64'h66, 0);
        tick();
        set_port(0, 1, 0, 64'h77, 0);
        set_port(1, 1, 0, 64'h88, 0);
        tick();
        check("ra_alert", alert, 1);
        rst = 1'b1;
        tick();
        check("ra_alert_clr", alert, 0);
        check("ra_depth", depth, 0);
        check("ra_busy", busy, 0);

        // enable low clears stack and suppresses checks
        set_port(0, 1, 0, 64'hA0, 0);
        set_port(1, 1, 0, 64'hB0, 0);
        tick(); tick(); tick();
        check("en_depth2", depth, 2);
        enable = 1'b0;
        tick();
        check("en_cleared", depth, 0);
        set_port(0, 0, 1, 0, 64'hDEAD);
        tick(); tick();
        check("en_noalert", alert, 0);
        enable = 1'b1;
        tick();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            enable    = ($urandom_range(0, 19) != 0);
            alert_ack = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < NR_PORTS; p++) begin
                if ($urandom_range(0, 9) < 7) begin
                    set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             64'($urandom_range(1, 4) * 16), 64'($urandom_range(1, 4) * 16));
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
